// File: rtl/vec_mul8_array_top.sv
// Unsigned SIMD multiplier for the vector unit: a 4x4 array of 8x8 tiles feeds four
// registered 32-bit product words at SEW 8, 16 or 32 (32-bit SEW takes two passes).

module mul8_tile (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);

  assign p_o = {8'b0, a_i} * {8'b0, b_i};

endmodule

module vec_mul8_array_top (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  sew,
  input  logic        count_0,
  input  logic        start,
  input  logic [31:0] data_in_A1,
  input  logic [31:0] data_in_B1,
  input  logic [31:0] data_in_A2,
  input  logic [31:0] data_in_B2,
  output logic [31:0] product_1,
  output logic [31:0] product_2,
  output logic [31:0] product_3,
  output logic [31:0] product_4
);

  typedef enum logic [1:0] {
    SEW_8    = 2'b00,
    SEW_16   = 2'b01,
    SEW_32   = 2'b10,
    SEW_RSVD = 2'b11
  } sew_e;

  sew_e        sew_s;
  logic        is32;
  logic [31:0] wide_a, wide_b;
  logic [15:0] half_a [4];
  logic [15:0] half_b [4];

  logic [7:0]  tile_a [16];
  logic [7:0]  tile_b [16];
  logic [15:0] tile_p [16];
  logic [63:0] pp32   [16];

  logic [3:0][31:0] p8;
  logic [3:0][31:0] p16;
  logic [63:0]      p32;

  logic [3:0][31:0] prod_q, prod_d;

  assign sew_s  = sew_e'(sew);
  assign is32   = (sew_s == SEW_32);
  assign wide_a = count_0 ? data_in_A2 : data_in_A1;
  assign wide_b = count_0 ? data_in_B2 : data_in_B1;

  // Half-word k of the operands: k=0,1 from pair 1, k=2,3 from pair 2.
  assign half_a[0] = data_in_A1[15:0];
  assign half_a[1] = data_in_A1[31:16];
  assign half_a[2] = data_in_A2[15:0];
  assign half_a[3] = data_in_A2[31:16];
  assign half_b[0] = data_in_B1[15:0];
  assign half_b[1] = data_in_B1[31:16];
  assign half_b[2] = data_in_B2[15:0];
  assign half_b[3] = data_in_B2[31:16];

  // Tile (i,j) in 32b mode computes A byte i * B byte j of the selected pair.
  // Otherwise row i serves half-word i: j=0 lo*lo, j=1 lo*hi, j=2 hi*lo, j=3 hi*hi;
  // the 8b mode reuses the lo*lo and hi*hi tiles of each row.
  for (genvar i = 0; i < 4; i++) begin : g_row
    for (genvar j = 0; j < 4; j++) begin : g_col
      localparam int T = 4 * i + j;
      logic [7:0] small_a, small_b;

      if (j >= 2) begin : g_ahi
        assign small_a = half_a[i][15:8];
      end else begin : g_alo
        assign small_a = half_a[i][7:0];
      end

      if (j % 2 == 1) begin : g_bhi
        assign small_b = half_b[i][15:8];
      end else begin : g_blo
        assign small_b = half_b[i][7:0];
      end

      assign tile_a[T] = is32 ? wide_a[8*i +: 8] : small_a;
      assign tile_b[T] = is32 ? wide_b[8*j +: 8] : small_b;

      mul8_tile u_tile (
        .a_i (tile_a[T]),
        .b_i (tile_b[T]),
        .p_o (tile_p[T])
      );

      assign pp32[T] = {48'b0, tile_p[T]} << (8 * (i + j));
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_word
    assign p8[k]  = {tile_p[4*k+3], tile_p[4*k]};
    assign p16[k] = {16'b0, tile_p[4*k]}
                  + ({16'b0, tile_p[4*k+1]} << 8)
                  + ({16'b0, tile_p[4*k+2]} << 8)
                  + ({16'b0, tile_p[4*k+3]} << 16);
  end

  always_comb begin
    p32 = '0;
    for (int t = 0; t < 16; t++) begin
      p32 = p32 + pp32[t];
    end
  end

  // Reserved SEW and start=0 both leave every word untouched.
  always_comb begin
    prod_d = prod_q;
    if (start) begin
      case (sew_s)
        SEW_8:  prod_d = p8;
        SEW_16: prod_d = p16;
        SEW_32: begin
          if (count_0) begin
            prod_d[3] = p32[63:32];
            prod_d[2] = p32[31:0];
          end else begin
            prod_d[1] = p32[63:32];
            prod_d[0] = p32[31:0];
          end
        end
        default: prod_d = prod_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q <= '0;
    end else begin
      prod_q <= prod_d;
    end
  end

  assign product_1 = prod_q[0];
  assign product_2 = prod_q[1];
  assign product_3 = prod_q[2];
  assign product_4 = prod_q[3];

endmodule

// File: tb/tb_vec_mul8_array_top.sv
// Directed and randomised checks of vec_mul8_array_top against a plain
// full-width multiply model of the four product words.

module tb_vec_mul8_array_top;

  logic        clk;
  logic        reset;
  logic [1:0]  sew;
  logic        count_0;
  logic        start;
  logic [31:0] a1, b1, a2, b2;
  logic [31:0] p1, p2, p3, p4;

  int n_checks;
  int n_errors;

  vec_mul8_array_top dut (
    .clk        (clk),
    .reset      (reset),
    .sew        (sew),
    .count_0    (count_0),
    .start      (start),
    .data_in_A1 (a1),
    .data_in_B1 (b1),
    .data_in_A2 (a2),
    .data_in_B2 (b2),
    .product_1  (p1),
    .product_2  (p2),
    .product_3  (p3),
    .product_4  (p4)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] s, input logic c, input logic st,
                       input logic [31:0] x1, input logic [31:0] y1,
                       input logic [31:0] x2, input logic [31:0] y2);
    sew = s; count_0 = c; start = st;
    a1 = x1; b1 = y1; a2 = x2; b2 = y2;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive(2'b01, 1'b0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    n_checks++;
    if ({p4, p3, p2, p1} !== 128'h0) begin
      n_errors++;
      $display("FAIL reset: got %h %h %h %h expected all zero", p4, p3, p2, p1);
    end
    reset = 1'b0;
  endtask

  task automatic test_sew16();
    drive(2'b01, 1'b0, 1'b1, 32'h670432F8, 32'h1692ABC3, 32'h0000_FFFF, 32'hFFFF_FFFF);
    tick();
    n_checks++;
    if (p1 !== 32'h22327AE8) begin
      n_errors++; $display("FAIL sew16_p1: got %h expected 22327ae8", p1);
    end
    n_checks++;
    if (p2 !== 32'h09151848) begin
      n_errors++; $display("FAIL sew16_p2: got %h expected 09151848", p2);
    end
    n_checks++;
    if (p3 !== 32'hFFFE0001) begin
      n_errors++; $display("FAIL sew16_p3: got %h expected fffe0001", p3);
    end
    n_checks++;
    if (p4 !== 32'h00000000) begin
      n_errors++; $display("FAIL sew16_p4: got %h expected 00000000", p4);
    end
  endtask

  task automatic test_sew8();
    drive(2'b00, 1'b1, 1'b1, 32'h0302FF10, 32'h0405FF10, 32'h8001FF02, 32'h02FF0103);
    tick();
    n_checks++;
    if (p1 !== 32'hFE010100) begin
      n_errors++; $display("FAIL sew8_p1: got %h expected fe010100", p1);
    end
    n_checks++;
    if (p2 !== 32'h000C000A) begin
      n_errors++; $display("FAIL sew8_p2: got %h expected 000c000a", p2);
    end
    n_checks++;
    if (p3 !== 32'h00FF0006) begin
      n_errors++; $display("FAIL sew8_p3: got %h expected 00ff0006", p3);
    end
    n_checks++;
    if (p4 !== 32'h010000FF) begin
      n_errors++; $display("FAIL sew8_p4: got %h expected 010000ff", p4);
    end
  endtask

  task automatic test_sew32();
    drive(2'b10, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010000, 32'h00010000);
    tick();
    n_checks++;
    if ({p2, p1} !== 64'hFFFFFFFE_00000001) begin
      n_errors++; $display("FAIL sew32_pass0: got %h_%h expected fffffffe_00000001", p2, p1);
    end
    n_checks++;
    if ({p4, p3} !== 64'h010000FF_00FF0006) begin
      n_errors++; $display("FAIL sew32_pass0_hold34: got %h_%h expected 010000ff_00ff0006", p4, p3);
    end
    drive(2'b10, 1'b1, 1'b1, 32'h0, 32'h0, 32'h00010000, 32'h00010000);
    tick();
    n_checks++;
    if ({p4, p3} !== 64'h00000001_00000000) begin
      n_errors++; $display("FAIL sew32_pass1: got %h_%h expected 00000001_00000000", p4, p3);
    end
    n_checks++;
    if ({p2, p1} !== 64'hFFFFFFFE_00000001) begin
      n_errors++; $display("FAIL sew32_pass1_hold12: got %h_%h expected fffffffe_00000001", p2, p1);
    end
  endtask

  // Reset between the two passes discards pass 0; a lone pass 1 then fills only words 3/4.
  task automatic test_reset_mid32();
    drive(2'b10, 1'b0, 1'b1, 32'hDEADBEEF, 32'h12345678, 32'h0, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(2'b10, 1'b1, 1'b1, 32'h0, 32'h0, 32'h80000000, 32'h00000003);
    tick();
    n_checks++;
    if ({p4, p3, p2, p1} !== {32'h00000001, 32'h80000000, 64'h0}) begin
      n_errors++;
      $display("FAIL reset_mid32: got %h %h %h %h expected 00000001 80000000 0 0", p4, p3, p2, p1);
    end
  endtask

  task automatic test_hold();
    drive(2'b01, 1'b0, 1'b1, 32'h00030002, 32'h00050007, 32'h00FF0100, 32'h00020010);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 1'b0, 1'b0, $urandom, $urandom, $urandom, $urandom);
      tick();
    end
    n_checks++;
    if ({p4, p3, p2, p1} !== {32'h000001FE, 32'h00001000, 32'h0000000F, 32'h0000000E}) begin
      n_errors++; $display("FAIL hold_start0: got %h %h %h %h expected 000001fe 00001000 0000000f 0000000e", p4, p3, p2, p1);
    end
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, i[0], 1'b1, $urandom, $urandom, $urandom, $urandom);
      tick();
    end
    n_checks++;
    if ({p4, p3, p2, p1} !== {32'h000001FE, 32'h00001000, 32'h0000000F, 32'h0000000E}) begin
      n_errors++; $display("FAIL hold_sew11: got %h %h %h %h expected 000001fe 00001000 0000000f 0000000e", p4, p3, p2, p1);
    end
  endtask

  // Random vectors per SEW, scored against a full-width multiply model.
  task automatic test_random(input logic [1:0] s);
    logic [3:0][31:0] exp_w;
    logic [31:0]      x1, y1, x2, y2;
    logic [63:0]      wide;
    logic [31:0]      xa, yb;
    logic             st, c, rst;
    int               errs_before;
    errs_before = n_errors;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_w = '0;
    for (int n = 0; n < 1000; n++) begin
      x1 = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
      y1 = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
      x2 = $urandom;
      y2 = ($urandom_range(0, 15) == 0) ? 32'h0 : $urandom;
      st  = ($urandom_range(0, 3) != 0);
      c   = $urandom_range(0, 1);
      rst = ($urandom_range(0, 99) == 0);
      drive(s, c, st, x1, y1, x2, y2);
      reset = rst;
      if (rst) begin
        exp_w = '0;
      end else if (st) begin
        case (s)
          2'b00: begin
            for (int k = 0; k < 4; k++) begin
              xa = (k < 2) ? x1 : x2;
              yb = (k < 2) ? y1 : y2;
              exp_w[k][15:0]  = {8'b0, xa[16*(k%2) +: 8]}   * {8'b0, yb[16*(k%2) +: 8]};
              exp_w[k][31:16] = {8'b0, xa[16*(k%2)+8 +: 8]} * {8'b0, yb[16*(k%2)+8 +: 8]};
            end
          end
          2'b01: begin
            for (int k = 0; k < 4; k++) begin
              xa = (k < 2) ? x1 : x2;
              yb = (k < 2) ? y1 : y2;
              exp_w[k] = {16'b0, xa[16*(k%2) +: 16]} * {16'b0, yb[16*(k%2) +: 16]};
            end
          end
          2'b10: begin
            wide = c ? ({32'b0, x2} * {32'b0, y2}) : ({32'b0, x1} * {32'b0, y1});
            if (c) begin
              exp_w[3] = wide[63:32]; exp_w[2] = wide[31:0];
            end else begin
              exp_w[1] = wide[63:32]; exp_w[0] = wide[31:0];
            end
          end
          default: exp_w = exp_w;
        endcase
      end
      tick();
      n_checks++;
      if ({p4, p3, p2, p1} !== exp_w) begin
        n_errors++;
        if (n_errors - errs_before <= 5)
          $display("FAIL random_sew%0d[%0d]: got %h %h %h %h expected %h %h %h %h",
                   s, n, p4, p3, p2, p1, exp_w[3], exp_w[2], exp_w[1], exp_w[0]);
      end
    end
    reset = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    drive(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (2) tick();
    test_reset();
    test_sew16();
    test_sew8();
    test_sew32();
    test_reset_mid32();
    test_hold();
    for (int s = 0; s < 4; s++) test_random(s[1:0]);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
